// File: rtl/mtm_alu_deserializer.sv
// Serial frame receiver for the MTM ALU. It collects eight data bytes into
// operands B and A, then on a command frame publishes them together with the
// command byte.
module mtm_alu_deserializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        sin,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [7:0]  ctl_out,
  output logic        pkt_valid,
  output logic        err_frame,
  output logic        err_data
);

  localparam int unsigned FRAME_BITS   = 10;  // type + 8 payload + stop
  localparam int unsigned BUF_BYTES    = 8;
  localparam int unsigned CNT_W        = 4;
  localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] BYTE_CNT_MAX = CNT_W'(9);
  localparam logic [CNT_W-1:0] BYTE_CNT_PKT = CNT_W'(BUF_BYTES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RX        = 2'd1,
    WAIT_HIGH = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shift_q;
  logic                    frame_done;
  logic [CNT_W-1:0]        byte_cnt;
  logic [7:0]              byte_buf [BUF_BYTES];

  // Fields of the last completed frame; shift_q only moves while in RX
  logic       frame_type_c;
  logic [7:0] payload_c;
  logic       stop_c;

  assign frame_type_c = shift_q[9];
  assign payload_c    = shift_q[8:1];
  assign stop_c       = shift_q[0];

  // Frame receiver FSM: start detection, bit shifting, stop-bit recovery
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_q    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!sin) begin
            state   <= RX;
            bit_cnt <= '0;
          end
        end
        RX: begin
          shift_q <= {shift_q[FRAME_BITS-2:0], sin};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt    <= '0;
            frame_done <= 1'b1;
            // A low stop bit must not be mistaken for the next start bit
            state      <= sin ? IDLE : WAIT_HIGH;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (sin) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Packet assembly: byte buffering, operand publish and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt  <= '0;
      for (int i = 0; i < int'(BUF_BYTES); i++) begin
        byte_buf[i] <= '0;
      end
      a_out     <= '0;
      b_out     <= '0;
      ctl_out   <= '0;
      pkt_valid <= 1'b0;
      err_frame <= 1'b0;
      err_data  <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      err_frame <= 1'b0;
      err_data  <= 1'b0;
      if (frame_done) begin
        if (!stop_c) begin
          // Bad framing drops whatever partial packet was being built
          err_frame <= 1'b1;
          byte_cnt  <= '0;
        end else if (frame_type_c) begin
          byte_cnt <= '0;
          if (byte_cnt == BYTE_CNT_PKT) begin
            b_out     <= {byte_buf[0], byte_buf[1], byte_buf[2], byte_buf[3]};
            a_out     <= {byte_buf[4], byte_buf[5], byte_buf[6], byte_buf[7]};
            ctl_out   <= payload_c;
            pkt_valid <= 1'b1;
          end else begin
            err_data <= 1'b1;
          end
        end else begin
          if (byte_cnt < BYTE_CNT_PKT) begin
            byte_buf[byte_cnt[2:0]] <= payload_c;
          end
          // Saturating count still flags an over-long packet at command time
          if (byte_cnt != BYTE_CNT_MAX) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for the MTM ALU serial deserializer.
module tb_mtm_alu_deserializer;

  logic        clk;
  logic        reset;
  logic        sin;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [7:0]  ctl_out;
  logic        pkt_valid;
  logic        err_frame;
  logic        err_data;

  int checks   = 0;
  int failures = 0;

  int n_pv = 0;
  int n_ef = 0;
  int n_ed = 0;
  int n_overlap = 0;
  int pv0, ef0, ed0;

  mtm_alu_deserializer dut (
    .clk      (clk),
    .reset    (reset),
    .sin      (sin),
    .a_out    (a_out),
    .b_out    (b_out),
    .ctl_out  (ctl_out),
    .pkt_valid(pkt_valid),
    .err_frame(err_frame),
    .err_data (err_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (pkt_valid === 1'b1) n_pv++;
    if (err_frame === 1'b1) n_ef++;
    if (err_data  === 1'b1) n_ed++;
    if ((int'(pkt_valid) + int'(err_frame) + int'(err_data)) > 1) n_overlap++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin = 1'b1;
    end
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop);
    @(negedge clk); sin = 1'b0;
    @(negedge clk); sin = typ;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); sin = pl[i];
    end
    @(negedge clk); sin = stop;
  endtask

  task automatic send_pkt(input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] ctl, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_frame(1'b0, 8'(b >> (24 - 8 * i)), 1'b1);
      idle(gap);
    end
    for (int i = 0; i < 4; i++) begin
      send_frame(1'b0, 8'(a >> (24 - 8 * i)), 1'b1);
      idle(gap);
    end
    send_frame(1'b1, ctl, 1'b1);
    idle(4);
  endtask

  task automatic snap();
    pv0 = n_pv;
    ef0 = n_ef;
    ed0 = n_ed;
  endtask

  task automatic check_pulses(input string name, input int epv, input int eef, input int eed);
    // per-scenario pulse deltas are compared inline by the callers
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_out !== 32'h0 || b_out !== 32'h0 || ctl_out !== 8'h0) begin
      failures++;
      $display("FAIL reset_outputs a=%h b=%h ctl=%h required all zero", a_out, b_out, ctl_out);
    end
    checks++;
    if ({pkt_valid, err_frame, err_data} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000", {pkt_valid, err_frame, err_data});
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good_gap();
    snap();
    send_pkt(32'h0000_0002, 32'h0000_0001, 8'h80, 2);
    checks++;
    if ((n_pv - pv0) !== 1 || (n_ef - ef0) !== 0 || (n_ed - ed0) !== 0) begin
      failures++;
      $display("FAIL good_gap_pulses pv=%0d ef=%0d ed=%0d required 1/0/0", n_pv - pv0, n_ef - ef0, n_ed - ed0);
    end
    checks++;
    if (b_out !== 32'h0000_0001 || a_out !== 32'h0000_0002 || ctl_out !== 8'h80) begin
      failures++;
      $display("FAIL good_gap_data a=%h b=%h ctl=%h required a=00000002 b=00000001 ctl=80", a_out, b_out, ctl_out);
    end
  endtask

  task automatic test_back_to_back();
    snap();
    send_pkt(32'h0000_0002, 32'h0000_0001, 8'h80, 0);
    checks++;
    if ((n_pv - pv0) !== 1 || (n_ef - ef0) !== 0 || (n_ed - ed0) !== 0) begin
      failures++;
      $display("FAIL b2b_pulses pv=%0d ef=%0d ed=%0d required 1/0/0", n_pv - pv0, n_ef - ef0, n_ed - ed0);
    end
    checks++;
    if (b_out !== 32'h0000_0001 || a_out !== 32'h0000_0002 || ctl_out !== 8'h80) begin
      failures++;
      $display("FAIL b2b_data a=%h b=%h ctl=%h required a=00000002 b=00000001 ctl=80", a_out, b_out, ctl_out);
    end
    snap();
    send_pkt(32'hDEAD_BEEF, 32'h1234_5678, 8'h8F, 0);
    checks++;
    if ((n_pv - pv0) !== 1 || (n_ed - ed0) !== 0) begin
      failures++;
      $display("FAIL b2b2_pulses pv=%0d ed=%0d required 1/0", n_pv - pv0, n_ed - ed0);
    end
    checks++;
    if (b_out !== 32'h1234_5678 || a_out !== 32'hDEAD_BEEF || ctl_out !== 8'h8F) begin
      failures++;
      $display("FAIL b2b2_data a=%h b=%h ctl=%h required a=deadbeef b=12345678 ctl=8f", a_out, b_out, ctl_out);
    end
  endtask

  task automatic test_short();
    snap();
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b0, 8'h33, 1'b1);
    send_frame(1'b1, 8'h81, 1'b1);
    idle(4);
    checks++;
    if ((n_ed - ed0) !== 1 || (n_pv - pv0) !== 0 || (n_ef - ef0) !== 0) begin
      failures++;
      $display("FAIL short_pulses pv=%0d ef=%0d ed=%0d required 0/0/1", n_pv - pv0, n_ef - ef0, n_ed - ed0);
    end
    checks++;
    if (b_out !== 32'h1234_5678 || a_out !== 32'hDEAD_BEEF || ctl_out !== 8'h8F) begin
      failures++;
      $display("FAIL short_hold a=%h b=%h ctl=%h required a=deadbeef b=12345678 ctl=8f", a_out, b_out, ctl_out);
    end
    // A full packet straight after proves the byte count restarted at zero
    snap();
    send_pkt(32'hA5A5_0F0F, 32'h0102_0304, 8'h83, 1);
    checks++;
    if ((n_pv - pv0) !== 1 || (n_ed - ed0) !== 0 || a_out !== 32'hA5A5_0F0F || b_out !== 32'h0102_0304) begin
      failures++;
      $display("FAIL short_recover pv=%0d ed=%0d a=%h b=%h required 1/0 a=a5a50f0f b=01020304", n_pv - pv0, n_ed - ed0, a_out, b_out);
    end
  endtask

  task automatic test_bad_stop();
    snap();
    send_frame(1'b0, 8'hAA, 1'b0);
    repeat (5) begin
      @(negedge clk); sin = 1'b0;
    end
    idle(4);
    checks++;
    if ((n_ef - ef0) !== 1 || (n_pv - pv0) !== 0 || (n_ed - ed0) !== 0) begin
      failures++;
      $display("FAIL bad_stop_pulses pv=%0d ef=%0d ed=%0d required 0/1/0", n_pv - pv0, n_ef - ef0, n_ed - ed0);
    end
    snap();
    send_pkt(32'h0BAD_F00D, 32'hCAFE_1234, 8'h84, 0);
    checks++;
    if ((n_pv - pv0) !== 1 || (n_ed - ed0) !== 0 || (n_ef - ef0) !== 0) begin
      failures++;
      $display("FAIL bad_stop_next_pulses pv=%0d ef=%0d ed=%0d required 1/0/0", n_pv - pv0, n_ef - ef0, n_ed - ed0);
    end
    checks++;
    if (a_out !== 32'h0BAD_F00D || b_out !== 32'hCAFE_1234 || ctl_out !== 8'h84) begin
      failures++;
      $display("FAIL bad_stop_next_data a=%h b=%h ctl=%h required a=0badf00d b=cafe1234 ctl=84", a_out, b_out, ctl_out);
    end
  endtask

  task automatic test_long();
    snap();
    for (int i = 0; i < 9; i++) begin
      send_frame(1'b0, 8'(8'h40 + i), 1'b1);
    end
    send_frame(1'b1, 8'h82, 1'b1);
    idle(4);
    checks++;
    if ((n_ed - ed0) !== 1 || (n_pv - pv0) !== 0 || (n_ef - ef0) !== 0) begin
      failures++;
      $display("FAIL long_pulses pv=%0d ef=%0d ed=%0d required 0/0/1", n_pv - pv0, n_ef - ef0, n_ed - ed0);
    end
    checks++;
    if (a_out !== 32'h0BAD_F00D || b_out !== 32'hCAFE_1234 || ctl_out !== 8'h84) begin
      failures++;
      $display("FAIL long_hold a=%h b=%h ctl=%h required a=0badf00d b=cafe1234 ctl=84", a_out, b_out, ctl_out);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] pl;
    pl = 8'hF0;
    // Two stored bytes, then a frame cut by reset during payload bit 4
    send_frame(1'b0, 8'h77, 1'b1);
    send_frame(1'b0, 8'h66, 1'b1);
    @(negedge clk); sin = 1'b0;
    @(negedge clk); sin = 1'b0;
    for (int i = 7; i >= 4; i--) begin
      @(negedge clk); sin = pl[i];
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sin   = 1'b1;
    checks++;
    if (a_out !== 32'h0 || b_out !== 32'h0 || ctl_out !== 8'h0 ||
        {pkt_valid, err_frame, err_data} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_outputs a=%h b=%h ctl=%h flags=%b required all zero", a_out, b_out, ctl_out, {pkt_valid, err_frame, err_data});
    end
    idle(3);
    snap();
    send_pkt(32'h8765_4321, 32'h1357_9BDF, 8'h85, 1);
    checks++;
    if ((n_pv - pv0) !== 1 || (n_ed - ed0) !== 0 || (n_ef - ef0) !== 0) begin
      failures++;
      $display("FAIL mid_reset_next_pulses pv=%0d ef=%0d ed=%0d required 1/0/0", n_pv - pv0, n_ef - ef0, n_ed - ed0);
    end
    checks++;
    if (a_out !== 32'h8765_4321 || b_out !== 32'h1357_9BDF || ctl_out !== 8'h85) begin
      failures++;
      $display("FAIL mid_reset_next_data a=%h b=%h ctl=%h required a=87654321 b=13579bdf ctl=85", a_out, b_out, ctl_out);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (n_overlap !== 0) begin
      failures++;
      $display("FAIL pulse_exclusive overlap_cycles=%0d required=0", n_overlap);
    end
  endtask

  initial begin
    reset = 1'b1;
    sin   = 1'b1;
    test_reset();
    test_good_gap();
    test_back_to_back();
    test_short();
    test_bad_stop();
    test_long();
    test_mid_reset();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mtm_alu_deserializer.md
MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port sin, input, 1 bit: serial frame input; idles high.
REQ-004 The block SHALL have port a_out, output, 32 bits: operand A of the last good packet.
REQ-005 The block SHALL have port b_out, output, 32 bits: operand B of the last good packet.
REQ-006 The block SHALL have port ctl_out, output, 8 bits: command byte of the last good packet.
REQ-007 The block SHALL have port pkt_valid, output, 1 bit: one-cycle pulse marking a good packet.
REQ-008 The block SHALL have port err_frame, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port err_data, output, 1 bit: one-cycle pulse on a wrong data-byte count.

Function
REQ-010 Frame format SHALL be 11 bits, one bit per clock, in this order:
- start bit = 0;
- type bit: 0 = data, 1 = command;
- 8 payload bits, MSB first;
- stop bit = 1.
REQ-011 FSM states SHALL be IDLE, RX, WAIT_HIGH.
REQ-012 IDLE: when sin=0 is sampled, go to RX with bit_cnt cleared to 0.
REQ-013 RX: shift sin into a 10-bit shift register every clock and increment bit_cnt.
REQ-014 RX: at the edge that samples the 10th bit (the stop bit), the frame is complete.
- stop=1: go to IDLE.
- stop=0: go to WAIT_HIGH.
REQ-015 WAIT_HIGH: stay until sin=1 is sampled, then go to IDLE; a low sin in this state is never taken as a start bit.
REQ-016 Frames arriving back-to-back SHALL be accepted, i.e. a start bit in the first IDLE cycle after a stop bit; inter-frame gaps of any length SHALL also be accepted.
REQ-017 A good data frame SHALL be stored at index byte_cnt of an 8-byte buffer, and byte_cnt incremented.
- byte_cnt is 4 bits and saturates at 9.
- Bytes at index 8 and above are not stored.
REQ-018 Data byte order SHALL be: bytes 0..3 = B[31:24], B[23:16], B[15:8], B[7:0]; bytes 4..7 = A[31:24] .. A[7:0].
REQ-019 For a good command frame with byte_cnt=8, the edge after the stop bit is sampled SHALL:
- load b_out and a_out from the buffer;
- load ctl_out with the payload;
- pulse pkt_valid for exactly 1 cycle.
REQ-020 For a good command frame with byte_cnt!=8 (0..7 or 9): pulse err_data for 1 cycle, leave a_out/b_out/ctl_out unchanged, no pkt_valid.
REQ-021 Any command frame, good or error, SHALL clear byte_cnt to 0.
REQ-022 Stop bit = 0 SHALL:
- pulse err_frame for 1 cycle, on the edge after the stop bit is sampled;
- discard the frame;
- clear byte_cnt to 0, dropping the partial packet.
REQ-023 pkt_valid, err_frame and err_data SHALL be registered and mutually exclusive in any cycle.
REQ-024 a_out, b_out and ctl_out SHALL hold their values between pkt_valid pulses.

Reset
REQ-025 On any edge with reset=1, including mid-frame or in WAIT_HIGH, the block SHALL:
- go to IDLE;
- set bit_cnt=0, byte_cnt=0, buffer=0;
- set a_out=0, b_out=0, ctl_out=0;
- set pkt_valid=0, err_frame=0, err_data=0.
REQ-026 A frame in progress at reset SHALL be lost; the first start bit sampled after reset deasserts SHALL begin a new frame.

Verification
REQ-027 Good packet: data 00 00 00 01 00 00 00 02, then command 0x80, with 2 idle clocks between frames.
- Required: one pkt_valid pulse, b_out=0x00000001, a_out=0x00000002, ctl_out=0x80, no error pulses.
REQ-028 Same packet sent with zero gap between frames -> identical outputs to REQ-027.
REQ-029 Short packet: data 11 22 33, then command 0x81 -> one err_data pulse, outputs keep their prior values, byte_cnt=0.
REQ-030 Bad stop bit: frame 0,0,0xAA,0, then sin held 0 for 5 clocks, then 1.
- Required: one err_frame pulse, no start detected until sin returns high.
- A following good 8+1 packet is decoded correctly.
REQ-031 Long packet: 9 data bytes, then command 0x82 -> one err_data pulse, no pkt_valid.
REQ-032 Reset mid-frame: reset=1 for 1 cycle during payload bit 4.
- Required: all outputs 0.
- A complete packet sent afterwards decodes correctly.
